// File: rtl/johnson_grey_reader.sv
// Receive side of the three-decade Johnson counter: synchronise, debounce,
// validate and decode to BCD/binary, and check for +1 mod 1000 progression.
//
// state | meaning
// IDLE  | waiting for a stable, new candidate word
// MAC1  | acc = hundreds*10 + tens
// MAC2  | acc = acc*10 + ones
// OUT   | publish value, run the step check
module johnson_grey_reader #(
  parameter int pSTABLE = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_100,
  input  logic [4:0]  i_010,
  input  logic [4:0]  i_001,
  output logic [11:0] o_bcd,
  output logic [9:0]  o_bin,
  output logic        o_valid,
  output logic        o_err_code,
  output logic        o_err_step
);

  typedef enum logic [1:0] {IDLE, MAC1, MAC2, OUT} state_t;

  localparam logic [7:0] STABLE_TC = 8'(pSTABLE);

  state_t      state;
  state_t      state_nx;
  logic [14:0] sync_1;
  logic [14:0] w;
  logic [14:0] w_prev;
  logic [14:0] w_q;
  logic [14:0] last_word;
  logic [7:0]  stab_cnt;
  logic        stable;
  logic        stable_q;
  logic        rejected;
  logic        first;
  logic [3:0]  d100;
  logic [3:0]  d010;
  logic [3:0]  d001;
  logic [9:0]  acc;
  logic [4:0]  dec_100;
  logic [4:0]  dec_010;
  logic [4:0]  dec_001;
  logic        cand_legal;
  logic        candidate;
  logic        accept;
  logic        discard;
  logic [9:0]  bin_next;

  // Returns {legal, digit}.
  function automatic logic [4:0] j2d(input logic [4:0] code);
    case (code)
      5'b00000: j2d = {1'b1, 4'd0};
      5'b00001: j2d = {1'b1, 4'd1};
      5'b00011: j2d = {1'b1, 4'd2};
      5'b00111: j2d = {1'b1, 4'd3};
      5'b01111: j2d = {1'b1, 4'd4};
      5'b11111: j2d = {1'b1, 4'd5};
      5'b11110: j2d = {1'b1, 4'd6};
      5'b11100: j2d = {1'b1, 4'd7};
      5'b11000: j2d = {1'b1, 4'd8};
      5'b10000: j2d = {1'b1, 4'd9};
      default:  j2d = 5'b00000;
    endcase
  endfunction

  function automatic logic [9:0] x10(input logic [9:0] x);
    x10 = (x << 3) + (x << 1);
  endfunction

  // A word that changed this cycle is never stable, even if the counter
  // is still saturated from the previous word.
  assign stable     = (stab_cnt == STABLE_TC) && (w == w_prev);
  assign dec_100    = j2d(w_q[14:10]);
  assign dec_010    = j2d(w_q[9:5]);
  assign dec_001    = j2d(w_q[4:0]);
  assign cand_legal = dec_100[4] & dec_010[4] & dec_001[4];
  assign candidate  = stable_q && !rejected && (first || (w_q != last_word));
  assign bin_next   = (o_bin == 10'd999) ? 10'd0 : o_bin + 10'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_1   <= '0;
      w        <= '0;
      w_prev   <= '0;
      w_q      <= '0;
      stab_cnt <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_1   <= {i_100, i_010, i_001};
      w        <= sync_1;
      w_prev   <= w;
      w_q      <= w;
      stable_q <= stable;
      if (w != w_prev) begin
        stab_cnt <= '0;
      end else if (stab_cnt != STABLE_TC) begin
        stab_cnt <= stab_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    discard  = 1'b0;
    case (state)
      IDLE: begin
        if (candidate) begin
          accept  = cand_legal;
          discard = !cand_legal;
          if (cand_legal) begin
            state_nx = MAC1;
          end
        end
      end
      MAC1:    state_nx = MAC2;
      MAC2:    state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      first      <= 1'b1;
      rejected   <= 1'b0;
      last_word  <= '0;
      d100       <= '0;
      d010       <= '0;
      d001       <= '0;
      acc        <= '0;
      o_bin      <= '0;
      o_bcd      <= '0;
      o_valid    <= 1'b0;
      o_err_code <= 1'b0;
      o_err_step <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      // The rejection holds only until the rejected word stops being stable.
      if (!stable_q) begin
        rejected <= 1'b0;
      end else if (discard) begin
        rejected <= 1'b1;
      end
      if (discard) begin
        o_err_code <= 1'b1;
      end
      if (accept) begin
        d100      <= dec_100[3:0];
        d010      <= dec_010[3:0];
        d001      <= dec_001[3:0];
        last_word <= w_q;
      end
      case (state)
        MAC1: acc <= x10({6'b0, d100}) + {6'b0, d010};
        MAC2: acc <= x10(acc) + {6'b0, d001};
        OUT: begin
          o_bin   <= acc;
          o_bcd   <= {d100, d010, d001};
          o_valid <= 1'b1;
          first   <= 1'b0;
          if (!first && (acc != bin_next)) begin
            o_err_step <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_grey_reader.sv
// Directed + randomized bench for johnson_grey_reader against a value-level
// model of the counter readout (decode table, +1 mod 1000 rule, sticky flags).
module tb_johnson_grey_reader;

  localparam int P_STABLE = 4;
  localparam int WIN      = 24;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [4:0]  i_100;
  logic [4:0]  i_010;
  logic [4:0]  i_001;
  logic [11:0] o_bcd;
  logic [9:0]  o_bin;
  logic        o_valid;
  logic        o_err_code;
  logic        o_err_step;

  johnson_grey_reader #(.pSTABLE(P_STABLE)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_100      (i_100),
    .i_010      (i_010),
    .i_001      (i_001),
    .o_bcd      (o_bcd),
    .o_bin      (o_bin),
    .o_valid    (o_valid),
    .o_err_code (o_err_code),
    .o_err_step (o_err_step)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  logic [4:0] jtab [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

  bit          m_first;
  bit          m_have_last;
  logic [14:0] m_last;
  int          m_bin;
  int          m_bcd;
  bit          m_err_code;
  bit          m_err_step;
  int          exp_nval;

  int          win_nval;
  int          win_bin;
  int          win_bcd;

  function automatic int jdec(input logic [4:0] c);
    for (int i = 0; i < 10; i++) begin
      if (jtab[i] == c) return i;
    end
    return -1;
  endfunction

  function automatic logic [14:0] enc(input int v);
    return {jtab[v / 100], jtab[(v / 10) % 10], jtab[v % 10]};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic model_reset();
    m_first     = 1'b1;
    m_have_last = 1'b0;
    m_last      = '0;
    m_bin       = 0;
    m_bcd       = 0;
    m_err_code  = 1'b0;
    m_err_step  = 1'b0;
  endtask

  task automatic model_step(input logic [14:0] word);
    int dh, dt, d0, v;
    dh = jdec(word[14:10]);
    dt = jdec(word[9:5]);
    d0 = jdec(word[4:0]);
    if (m_have_last && word == m_last) begin
      exp_nval = 0;
    end else if (dh < 0 || dt < 0 || d0 < 0) begin
      exp_nval   = 0;
      m_err_code = 1'b1;
    end else begin
      v = dh * 100 + dt * 10 + d0;
      exp_nval = 1;
      if (!m_first && v != (m_bin + 1) % 1000) m_err_step = 1'b1;
      m_bin       = v;
      m_bcd       = dh * 256 + dt * 16 + d0;
      m_first     = 1'b0;
      m_last      = word;
      m_have_last = 1'b1;
    end
  endtask

  task automatic drive(input logic [14:0] word);
    i_100 = word[14:10];
    i_010 = word[9:5];
    i_001 = word[4:0];
  endtask

  task automatic run_window(input int n);
    repeat (n) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) begin
        win_nval++;
        win_bin = int'(o_bin);
        win_bcd = int'(o_bcd);
      end
    end
  endtask

  task automatic do_reset(input logic [14:0] word);
    @(negedge i_clk);
    drive(word);
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic hold_word(input string tag, input logic [14:0] word);
    drive(word);
    model_step(word);
    win_nval = 0;
    win_bin  = -1;
    win_bcd  = -1;
    run_window(WIN);
    check({tag, "_nvalid"}, win_nval, exp_nval);
    if (exp_nval == 1) begin
      check({tag, "_pulse_bin"}, win_bin, m_bin);
      check({tag, "_pulse_bcd"}, win_bcd, m_bcd);
    end
    check({tag, "_bin"}, int'(o_bin), m_bin);
    check({tag, "_err_code"}, int'(o_err_code), int'(m_err_code));
    check({tag, "_err_step"}, int'(o_err_step), int'(m_err_step));
  endtask

  initial begin
    logic [14:0] word;
    logic [4:0]  bad;
    int          lat;
    int          v;
    int          pos;

    i_rst = 1'b1;
    drive('0);

    // 1: reset values, then all-zero digits give a single pulse at P+5
    repeat (3) @(negedge i_clk);
    check("rst_valid", int'(o_valid), 0);
    check("rst_bin", int'(o_bin), 0);
    check("rst_bcd", int'(o_bcd), 0);
    check("rst_err_code", int'(o_err_code), 0);
    check("rst_err_step", int'(o_err_step), 0);
    i_rst = 1'b0;
    model_reset();
    model_step('0);
    win_nval = 0;
    lat      = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) begin
        win_nval++;
        if (lat < 0) lat = k;
      end
    end
    check("t1_nvalid", win_nval, exp_nval);
    check("t1_latency", lat, P_STABLE + 5);
    check("t1_bin", int'(o_bin), m_bin);
    check("t1_bcd", int'(o_bcd), m_bcd);
    check("t1_err_code", int'(o_err_code), 0);
    check("t1_err_step", int'(o_err_step), 0);

    // 2: 998 -> 999 -> 000 wrap is a legal step
    do_reset(enc(998));
    hold_word("t2_998", enc(998));
    hold_word("t2_999", enc(999));
    hold_word("t2_000", enc(0));

    // 3: a glitch shorter than the filter window is ignored
    do_reset(enc(5));
    hold_word("t3_005", enc(5));
    word = enc(5);
    drive({word[14:5], 5'b11110});
    win_nval = 0;
    run_window(P_STABLE - 1);
    drive(word);
    run_window(WIN);
    check("t3_nvalid", win_nval, 0);
    check("t3_bin", int'(o_bin), 5);
    check("t3_bcd", int'(o_bcd), 12'h005);

    // 4: illegal code is flagged and dropped; legal traffic resumes
    hold_word("t4_bad", {word[14:5], 5'b01010});
    hold_word("t4_006", enc(6));

    // 5: skipping a count raises the step error but still publishes
    do_reset(enc(5));
    hold_word("t5_005", enc(5));
    hold_word("t5_007", enc(7));

    // randomized traffic: mostly +1 steps, some jumps, repeats, illegal codes
    for (int n = 0; n < 30; n++) begin
      v = int'($urandom_range(0, 7));
      if (v == 0) begin
        do bad = 5'($urandom_range(0, 31)); while (jdec(bad) >= 0);
        pos  = int'($urandom_range(0, 2));
        word = enc(m_bin);
        word[pos*5 +: 5] = bad;
      end else if (v < 4) begin
        word = enc((m_bin + 1) % 1000);
      end else if (v == 4) begin
        word = m_have_last ? m_last : enc(0);
      end else begin
        word = enc(int'($urandom_range(0, 999)));
      end
      hold_word("rnd", word);
    end

    // 6: reset during MAC2 aborts the conversion
    @(negedge i_clk);
    drive('0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    win_nval = 0;
    run_window(P_STABLE + 3);
    i_rst = 1'b1;
    @(negedge i_clk);
    if (o_valid === 1'b1) win_nval++;
    check("t6_nvalid", win_nval, 0);
    check("t6_bin", int'(o_bin), 0);
    check("t6_bcd", int'(o_bcd), 0);
    check("t6_err_code", int'(o_err_code), 0);
    check("t6_err_step", int'(o_err_step), 0);
    drive(enc(500));
    i_rst = 1'b0;
    model_reset();
    hold_word("t6_500", enc(500));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
